eq_band_scheduler: RTL and testbench
====================================

# eq_band_scheduler

Controller that time-shares one IIR filter section across `NUM_BANDS` equalizer bands. Each accepted input sample goes through the shared datapath once per band. The scheduler weights each band's result by a programmable per-band gain, sums the weighted results, saturates the sum and emits one output sample. It sits between the sample source and the shared `iir_filter_5tabs` datapath, replacing one filter instance per band.

## Interface

Parameters:
- `DATA_BIT_NUM`, 16: sample width, signed two's complement.
- `NUM_BANDS`, 5: number of bands; must be 2..8.
- `BAND_W`, 3: band index width.
- `GAIN_BIT_NUM`, 8: gain width, unsigned Q2.6 (0x40 = 1.0).
- `TIMEOUT`, 64: maximum cycles to wait for `dp_done`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  scheduler can accept a sample.
- `in_data`  in  `DATA_BIT_NUM`  signed input sample.
- `gain_we`  in  1  gain register write strobe.
- `gain_addr`  in  `BAND_W`  band whose gain is written.
- `gain_data`  in  `GAIN_BIT_NUM`  gain value written.
- `dp_start`  out  1  one-cycle start pulse to the shared datapath.
- `dp_band`  out  `BAND_W`  band selector for datapath coefficients and state.
- `dp_data`  out  `DATA_BIT_NUM`  sample presented to the datapath.
- `dp_done`  in  1  datapath result valid; a single-cycle pulse.
- `dp_result`  in  `DATA_BIT_NUM`  signed datapath output.
- `out_valid`  out  1  one-cycle output strobe.
- `out_data`  out  `DATA_BIT_NUM`  signed, saturated weighted sum.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation

- **Reset values:**
  - `in_ready` = 1 after reset release.
  - All other outputs = 0.
  - Accumulator = 0, band counter = 0.
  - All gains = 0x40.
- **FSM states:** IDLE, ISSUE, WAIT, OUTPUT.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `in_data`, clear accumulator, set band = 0, go to ISSUE.
- **ISSUE:**
  - `dp_start` = 1 for exactly one cycle, with `dp_band` = band and `dp_data` = latched sample.
  - Clear the watchdog, go to WAIT.
- **WAIT:**
  - On `dp_done`: accumulator += `dp_result` × gain[band].
  - On watchdog reaching `TIMEOUT` without `dp_done`: add nothing, set `err` = 1.
  - On either event: if band == `NUM_BANDS`-1, go to OUTPUT; otherwise increment band and go to ISSUE.
- **OUTPUT:**
  - `out_data` = sat(acc >>> 6), with `out_valid` = 1 for one cycle.
  - Go to IDLE.
- `dp_band` and `dp_data` hold their values from ISSUE through WAIT.
- **Arithmetic:**
  - The gain is zero-extended before the multiply.
  - Product width is `DATA_BIT_NUM`+`GAIN_BIT_NUM`+1, signed.
  - Accumulator width is `DATA_BIT_NUM`+`GAIN_BIT_NUM`+4, signed, and never overflows.
  - The shift by 6 is arithmetic (truncates toward −∞).
  - Saturation clamps to [−2^(`DATA_BIT_NUM`−1), 2^(`DATA_BIT_NUM`−1)−1].
- **Gain writes:**
  - Accepted in any state; effective the next cycle.
  - A write to the band being accumulated in the same cycle as `dp_done` uses the old gain.
  - A write with `gain_addr` ≥ `NUM_BANDS` is ignored.
- **Boundary rules:**
  - `dp_done` outside WAIT is ignored.
  - `dp_done` arriving in the same cycle the watchdog expires counts as done: the result is added and `err` is not set.
  - `in_valid` while not in IDLE is not accepted; the sample source holds it.
  - Reset asserted mid-operation aborts immediately. A late `dp_done` after reset release is ignored, since the FSM is in IDLE.

## Timing

- Sample accepted at edge T. ISSUE for band 0 occupies cycle T+1.
- Datapath latency L ≥ 1: `dp_done` is high L cycles after `dp_start`.
- Each band takes 1+L cycles. `out_valid` is high in cycle T + `NUM_BANDS`·(1+L) + 1.
  - With L=1 and 5 bands: T+11.
- Throughput: one sample per `NUM_BANDS`·(1+L)+2 cycles, counting the IDLE accept cycle.
- A timed-out band takes 1+`TIMEOUT` cycles.

## Test plan

1. **Reset:** hold `rst`=0 with random inputs → all outputs 0. After release, `in_ready`=1 and `busy`=0.
2. **Unity gains:** datapath model returns `dp_data` with L=1. Input 0x0100 accepted at T → `dp_start` pulses at T+1, T+3, T+5, T+7, T+9 with `dp_band` 0..4. `out_valid` high at T+11 with `out_data` = 0x0500.
3. **Gain programming:** write gains 0x40, 0, 0x20, 0, 0 and input 0x0200 → `out_data` = 0x0300. Write to `gain_addr`=7 → no effect.
4. **Saturation:** unity gains, input 0x7FFF → 0x7FFF. Input 0x8000 → 0x8000. With all gains 0 → 0x0000.
5. **Timeout:** datapath withholds `dp_done` for band 2 only, input 0x0100 → `err` rises 64 cycles after band 2's `dp_start`, `out_data` = 0x0400, and `err` stays set.
6. **Reset mid-WAIT:** assert `rst` during band 3 WAIT, release, then pulse `dp_done` → no accumulation and no `out_valid`. The next sample produces the correct result.

Source files
------------

// File: rtl/eq_band_scheduler.sv
// Time-shares one IIR section across NUM_BANDS equalizer bands: issues each sample once per band,
// accumulates the gain-weighted results and emits one saturated output sample.
module eq_band_scheduler #(
    parameter int DATA_BIT_NUM = 16,
    parameter int NUM_BANDS    = 5,
    parameter int BAND_W       = 3,
    parameter int GAIN_BIT_NUM = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_BIT_NUM-1:0] in_data,
    input  logic                    gain_we,
    input  logic [BAND_W-1:0]       gain_addr,
    input  logic [GAIN_BIT_NUM-1:0] gain_data,
    output logic                    dp_start,
    output logic [BAND_W-1:0]       dp_band,
    output logic [DATA_BIT_NUM-1:0] dp_data,
    input  logic                    dp_done,
    input  logic [DATA_BIT_NUM-1:0] dp_result,
    output logic                    out_valid,
    output logic [DATA_BIT_NUM-1:0] out_data,
    output logic                    busy,
    output logic                    err
);

    localparam int PROD_W    = DATA_BIT_NUM + GAIN_BIT_NUM + 1;
    localparam int ACC_W     = DATA_BIT_NUM + GAIN_BIT_NUM + 4;
    localparam int WD_W      = $clog2(TIMEOUT + 1);
    localparam int GAIN_FRAC = 6;
    localparam logic [GAIN_BIT_NUM-1:0] GAIN_ONE = GAIN_BIT_NUM'(1 << GAIN_FRAC);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_BIT_NUM+1){1'b0}}, {(DATA_BIT_NUM-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t                    state, state_next;
    logic [DATA_BIT_NUM-1:0]   sample;
    logic [BAND_W-1:0]         band;
    logic signed [ACC_W-1:0]   acc;
    logic [WD_W-1:0]           wd;
    logic [GAIN_BIT_NUM-1:0]   gain [NUM_BANDS];
    logic                      ready_q;

    logic                      band_last;
    logic                      wd_expired;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   shifted;
    logic [DATA_BIT_NUM-1:0]   sat_data;

    assign band_last  = (band == BAND_W'(NUM_BANDS - 1));
    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
    // Gain is unsigned Q2.6: zero-extend before the signed multiply.
    assign product    = PROD_W'($signed(dp_result)) * PROD_W'($signed({1'b0, gain[band]}));
    assign shifted    = acc >>> GAIN_FRAC;

    always_comb begin
        if (shifted > SAT_MAX)
            sat_data = SAT_MAX[DATA_BIT_NUM-1:0];
        else if (shifted < SAT_MIN)
            sat_data = SAT_MIN[DATA_BIT_NUM-1:0];
        else
            sat_data = shifted[DATA_BIT_NUM-1:0];
    end

    assign in_ready = ready_q && (state == IDLE);
    assign busy     = (state != IDLE);
    assign dp_band  = band;
    assign dp_data  = sample;
    assign out_data = out_valid ? sat_data : '0;

    always_comb begin
        state_next = state;
        dp_start   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE:   if (in_valid && in_ready) state_next = ISSUE;
            ISSUE: begin
                dp_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT:   if (dp_done || wd_expired) state_next = band_last ? OUTPUT : ISSUE;
            OUTPUT: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sample  <= '0;
            band    <= '0;
            acc     <= '0;
            wd      <= '0;
            err     <= 1'b0;
            ready_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) gain[i] <= GAIN_ONE;
        end else begin
            state   <= state_next;
            ready_q <= 1'b1;
            if (gain_we && int'(gain_addr) < NUM_BANDS) gain[gain_addr] <= gain_data;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sample <= in_data;
                        acc    <= '0;
                        band   <= '0;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    // A result landing on the expiry cycle wins over the timeout.
                    if (dp_done)
                        acc <= acc + ACC_W'(product);
                    else if (wd_expired)
                        err <= 1'b1;
                    if ((dp_done || wd_expired) && !band_last) band <= band + BAND_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed and randomized checks of eq_band_scheduler against a sum-of-weighted-results model
// driven by a behavioural datapath responder with programmable latency.
module tb_eq_band_scheduler;

    localparam int DW = 16;
    localparam int NB = 5;
    localparam int BW = 3;
    localparam int GW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          gain_we;
    logic [BW-1:0] gain_addr;
    logic [GW-1:0] gain_data;
    logic          dp_start;
    logic [BW-1:0] dp_band;
    logic [DW-1:0] dp_data;
    logic          dp_done;
    logic [DW-1:0] dp_result = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          err;

    // Gain port is shared between the main sequence and the responder (same-cycle write test).
    logic          m_we = 1'b0;
    logic [BW-1:0] m_addr = '0;
    logic [GW-1:0] m_data = '0;
    logic          r_we = 1'b0;
    logic [BW-1:0] r_addr = '0;
    logic [GW-1:0] r_data = '0;
    logic          resp_done = 1'b0;
    logic          man_done = 1'b0;

    assign gain_we   = m_we | r_we;
    assign gain_addr = r_we ? r_addr : m_addr;
    assign gain_data = r_we ? r_data : m_data;
    assign dp_done   = resp_done | man_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    eq_band_scheduler #(
        .DATA_BIT_NUM(DW),
        .NUM_BANDS   (NB),
        .BAND_W      (BW),
        .GAIN_BIT_NUM(GW),
        .TIMEOUT     (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .gain_we  (gain_we),
        .gain_addr(gain_addr),
        .gain_data(gain_data),
        .dp_start (dp_start),
        .dp_band  (dp_band),
        .dp_data  (dp_data),
        .dp_done  (dp_done),
        .dp_result(dp_result),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy),
        .err      (err)
    );

    // Responder controls (written by the main sequence only)
    int            lat = 1;
    int            wh_band = -1;
    bit            res_mode = 1'b0;
    bit            sc_en = 1'b0;
    int            sc_band = 0;
    logic [GW-1:0] sc_val = '0;

    // Responder logs (written by the responder only)
    int            cnt = 0;
    logic [DW-1:0] pend_res = '0;
    int            pend_band = 0;
    logic [DW-1:0] res_log[$];
    int            band_log[$];
    int            start_cyc[$];
    int            start_band[$];
    int            err_rise = -1;
    bit            prev_err = 1'b0;

    // Main-sequence model state and counters
    int g_model[NB];
    int ncmp = 0;
    int nfail = 0;

    initial forever begin
        @(negedge clk);
        resp_done = 1'b0;
        r_we      = 1'b0;
        if (!rst) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_done = 1'b1;
                    dp_result = pend_res;
                    res_log.push_back(pend_res);
                    band_log.push_back(pend_band);
                    if (sc_en && pend_band == sc_band) begin
                        r_we   = 1'b1;
                        r_addr = BW'(sc_band);
                        r_data = sc_val;
                    end
                end
            end
            if (dp_start) begin
                start_cyc.push_back(cyc);
                start_band.push_back(int'(dp_band));
                if (int'(dp_band) != wh_band) begin
                    cnt       = lat;
                    pend_band = int'(dp_band);
                    pend_res  = res_mode ? DW'($urandom) : dp_data;
                end
            end
        end
        if (err && !prev_err) err_rise = cyc;
        prev_err = err;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_gain(input int addr, input int val);
        @(negedge clk);
        m_we   = 1'b1;
        m_addr = BW'(addr);
        m_data = GW'(val);
        @(negedge clk);
        m_we = 1'b0;
        if (addr < NB) g_model[addr] = val;
    endtask

    task automatic set_all_gains(input int val);
        for (int b = 0; b < NB; b++) write_gain(b, val);
    endtask

    function automatic longint sat_ref(input longint sum);
        longint q;
        q = sum >>> 6;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    // Sends one sample and checks band issue order/timing, output timing and output value.
    task automatic run_sample(input logic [DW-1:0] s, input string tag, output logic [DW-1:0] obs);
        int     base_r, base_s, c_t, guard, k, total, out_cyc, n_exp;
        longint sum;
        base_r = res_log.size();
        base_s = start_cyc.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = s;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, longint'(in_ready), 1);
        c_t = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        guard    = 0;
        while (!out_valid && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_out_valid"}, longint'(out_valid), 1);
        obs     = out_data;
        out_cyc = cyc;

        sum   = 0;
        total = 0;
        k     = base_r;
        for (int b = 0; b < NB; b++) begin
            if (base_s + b < start_cyc.size()) begin
                check({tag, "_start_cyc"}, start_cyc[base_s + b], c_t + 1 + total);
                check({tag, "_start_band"}, start_band[base_s + b], b);
            end else begin
                check({tag, "_start_missing"}, 0, 1);
            end
            if (b == wh_band) begin
                total += 1 + TO;
            end else begin
                if (k < res_log.size()) begin
                    check({tag, "_done_band"}, band_log[k], b);
                    sum += longint'($signed(res_log[k])) * g_model[b];
                    k++;
                end
                total += 1 + lat;
            end
        end
        n_exp = (wh_band >= 0 && wh_band < NB) ? NB - 1 : NB;
        check({tag, "_results"}, res_log.size() - base_r, n_exp);
        check({tag, "_out_cyc"}, out_cyc, c_t + total + 1);
        check({tag, "_out_data"}, longint'(obs), sat_ref(sum) & 64'hFFFF);
        @(negedge clk);
        check({tag, "_post_idle"}, longint'({busy, out_valid}), 0);
    endtask

    initial begin
        logic [DW-1:0] o;
        int            guard, base, seen;

        for (int b = 0; b < NB; b++) g_model[b] = 64;

        // Reset held with random inputs
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            m_we     = 1'($urandom);
            m_addr   = BW'($urandom);
            m_data   = GW'($urandom);
            man_done = 1'($urandom);
            #1;
            check("reset_outputs",
                  longint'({in_ready, busy, err, out_valid, dp_start, out_data, dp_band, dp_data}), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        m_we     = 1'b0;
        man_done = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("release_ready", longint'(in_ready), 1);
        check("release_busy", longint'(busy), 0);

        // Unity gains, echo datapath, L=1
        lat = 1;
        run_sample(16'h0100, "unity", o);
        check("unity_value", longint'(o), 16'h0500);

        // Gain programming, then an out-of-range write
        write_gain(0, 'h40);
        write_gain(1, 0);
        write_gain(2, 'h20);
        write_gain(3, 0);
        write_gain(4, 0);
        run_sample(16'h0200, "gains", o);
        check("gains_value", longint'(o), 16'h0300);
        write_gain(7, 0);
        run_sample(16'h0200, "gain_addr7", o);
        check("gain_addr7_value", longint'(o), 16'h0300);

        // Saturation
        set_all_gains(64);
        run_sample(16'h7FFF, "sat_pos", o);
        check("sat_pos_value", longint'(o), 16'h7FFF);
        run_sample(16'h8000, "sat_neg", o);
        check("sat_neg_value", longint'(o), 16'h8000);
        set_all_gains(0);
        run_sample(16'h7FFF, "zero_gain", o);
        check("zero_gain_value", longint'(o), 16'h0000);

        // Randomized gains, results and latency
        res_mode = 1'b1;
        repeat (6) begin
            for (int b = 0; b < NB; b++) write_gain(b, int'($urandom_range(0, 255)));
            write_gain(int'($urandom_range(NB, 7)), int'($urandom_range(0, 255)));
            lat = int'($urandom_range(1, 4));
            run_sample(DW'($urandom), "rand", o);
        end
        res_mode = 1'b0;

        // Gain write to the band being accumulated, same cycle as dp_done: old gain applies
        set_all_gains(64);
        lat     = 2;
        sc_band = 1;
        sc_val  = '0;
        sc_en   = 1'b1;
        run_sample(16'h0100, "same_cycle_wr", o);
        check("same_cycle_wr_value", longint'(o), 16'h0500);
        sc_en      = 1'b0;
        g_model[1] = 0;
        run_sample(16'h0100, "after_wr", o);
        check("after_wr_value", longint'(o), 16'h0400);

        // dp_done on the watchdog expiry cycle counts as done
        set_all_gains(64);
        lat = TO;
        run_sample(16'h0100, "done_at_expiry", o);
        check("done_at_expiry_value", longint'(o), 16'h0500);
        check("done_at_expiry_err", longint'(err), 0);
        lat = 1;

        // Timeout on band 2; err rises at the edge TIMEOUT cycles after dp_start drops
        wh_band = 2;
        base    = start_cyc.size();
        run_sample(16'h0100, "timeout", o);
        check("timeout_value", longint'(o), 16'h0400);
        if (base + 2 < start_cyc.size())
            check("timeout_err_rise", err_rise, start_cyc[base + 2] + TO + 1);
        else
            check("timeout_err_rise", 0, 1);
        wh_band = -1;
        run_sample(16'h0100, "post_timeout", o);
        check("err_sticky", longint'(err), 1);

        // Reset during band 3 WAIT, then a late dp_done
        wh_band = 3;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!(busy && dp_band == 3'd3 && !dp_start) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("midwait_reached", longint'(dp_band), 3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait_abort_busy", longint'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < NB; b++) g_model[b] = 64;
        @(negedge clk);
        check("midwait_err_cleared", longint'(err), 0);
        check("midwait_ready", longint'(in_ready), 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        seen     = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1;
        end
        check("late_done_ignored", seen, 0);
        wh_band = -1;
        run_sample(16'h0123, "after_reset", o);
        check("after_reset_value", longint'(o), 16'h05AF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
